l2_mem_responder: RTL and testbench
===================================

L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the backing array, power of two, at least 2.
REQ-002 SHALL have parameter RD_LATENCY, default 4: cycles from request acceptance to read response, at least 1.
REQ-003 SHALL have parameter WR_LATENCY, default 2: cycles from request acceptance to write commit, at least 1.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n as elsewhere in the codebase.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 l2_mem_en  in  1  request strobe from the bus arbiter.
REQ-008 l2_mem_wr_en  in  1  1 = write request, 0 = read request; qualified by l2_mem_en.
REQ-009 l2_mem_access_addr  in  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
REQ-010 l2_mem_wr_data  in  32  write data.
REQ-011 l2_mem_rd_data  out  32  registered read data.
REQ-012 l2_mem_rd_valid  out  1  one-cycle read-response pulse.
REQ-013 l2_mem_wr_done  out  1  one-cycle write-commit pulse.
REQ-014 l2_mem_busy  out  1  1 = request in flight; new requests are not accepted.
REQ-015 l2_mem_addr_err  out  1  one-cycle pulse marking an out-of-range access, coincident with rd_valid or wr_done.

Function
REQ-016 SHALL implement the FSM states IDLE, RD_WAIT, WR_WAIT and RESP; l2_mem_busy = (state != IDLE).
REQ-017 In IDLE, a rising edge with l2_mem_en=1 (acceptance edge E0) SHALL capture addr, wr_data and wr_en.
- At E0, the next state is RD_WAIT if wr_en=0, otherwise WR_WAIT.
- At E0, the latency counter loads (latency - 1).
REQ-018 Requests presented while busy=1 SHALL be ignored, not queued; the arbiter must hold or re-present them.
REQ-019 In RD_WAIT or WR_WAIT, the counter SHALL decrement each cycle.
- When counter == 0, the next edge (E0 + latency) moves to RESP.
REQ-020 Read: at edge E0+RD_LATENCY, l2_mem_rd_data SHALL load mem[idx], and rd_valid SHALL be 1 for exactly the following cycle.
REQ-021 Write: at edge E0+WR_LATENCY, mem[idx] SHALL be written, and wr_done SHALL be 1 for exactly the following cycle.
REQ-022 RESP SHALL last exactly one cycle, then return to IDLE.
- The earliest next acceptance edge is E0+latency+1.
REQ-023 l2_mem_rd_data SHALL hold its value between read responses; writes SHALL NOT alter it.
REQ-024 An out-of-range address (addr[31:log2(DEPTH_WORDS)+2] != 0) SHALL:
- pulse addr_err together with the response;
- return rd_data = 32'h0 for a read;
- leave the array unmodified for a write.
REQ-025 Input changes after E0 SHALL NOT affect the in-flight transaction.
REQ-026 A read that follows a write to the same word, accepted after wr_done, SHALL return the written data.
REQ-027 The counter SHALL be wide enough for max(RD_LATENCY, WR_LATENCY) - 1 and SHALL NOT wrap.

Reset
REQ-028 On rst_n=0 (asynchronous), the block SHALL force:
- state = IDLE, counter = 0;
- rd_data = 32'h0;
- rd_valid, wr_done, busy, addr_err = 0.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 Reset during WR_WAIT SHALL abort the write, with no array update; reset during RD_WAIT SHALL produce no rd_valid.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Write addr=0x10, data=0xA5A5_0001 at E0 -> busy=1 from E0; wr_done pulses one cycle after E0+2. Then read 0x10 -> rd_valid one cycle after E0'+4, rd_data=0xA5A5_0001.
REQ-033 Second l2_mem_en pulse held during the busy of a read to 0x20 -> ignored: one rd_valid only, captured addr unchanged; acceptance resumes at E0+5.
REQ-034 Read addr=0x0000_1000 (index 1024, out of range) -> rd_valid and addr_err together, rd_data=0x0; a write there is followed by a read of 0x0 returning the prior contents.
REQ-035 rst_n asserted 2 cycles into a write to 0x30 -> all outputs 0 immediately; no wr_done; a later read of 0x30 returns the old value.
REQ-036 Change addr/wr_data on the cycle after E0 of a write to 0x40 (data 0x1234_5678) -> 0x40 holds 0x1234_5678, and the new address is untouched.
REQ-037 Back-to-back reads to 0x4, 0x8 with l2_mem_en held high -> acceptances 5 cycles apart, rd_data sequence mem[1], mem[2].

Source files
------------

// File: rtl/l2_mem_responder.sv
// Single-port L2 backing memory with fixed read/write latencies, one request in flight.
// Responses are registered pulses; out-of-range accesses are flagged and never touch the array.
module l2_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 4,
    parameter int unsigned WR_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        l2_mem_en,
    input  logic        l2_mem_wr_en,
    input  logic [31:0] l2_mem_access_addr,
    input  logic [31:0] l2_mem_wr_data,
    output logic [31:0] l2_mem_rd_data,
    output logic        l2_mem_rd_valid,
    output logic        l2_mem_wr_done,
    output logic        l2_mem_busy,
    output logic        l2_mem_addr_err
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          oor_q;

    logic [31:0]   rd_data_q;
    logic          rd_valid_q;
    logic          wr_done_q;
    logic          addr_err_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept;
    logic          rd_fire;
    logic          wr_fire;
    logic          req_oor;
    logic          addr_lsb_unused;

    assign req_oor         = |l2_mem_access_addr[31:AW+2];
    assign addr_lsb_unused = ^l2_mem_access_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RESP also accepts, so back-to-back acceptances land exactly latency+1 edges apart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (l2_mem_en) begin
                    state_d = l2_mem_wr_en ? WR_WAIT : RD_WAIT;
                    cnt_d   = l2_mem_wr_en ? WR_LOAD : RD_LOAD;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        unique case (state_q)
            IDLE, RESP: accept  = l2_mem_en;
            RD_WAIT:    rd_fire = (cnt_q == '0);
            WR_WAIT:    wr_fire = (cnt_q == '0);
            default: ;
        endcase
    end

    assign l2_mem_busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            wdata_q    <= '0;
            oor_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            wr_done_q  <= wr_fire;
            addr_err_q <= (rd_fire | wr_fire) & oor_q;
            if (accept) begin
                idx_q   <= l2_mem_access_addr[AW+1:2];
                wdata_q <= l2_mem_wr_data;
                oor_q   <= req_oor;
            end
            if (rd_fire) begin
                rd_data_q <= oor_q ? '0 : mem_q[idx_q];
            end
        end
    end

    // Array is deliberately outside the reset domain; a reset before commit drops wr_fire.
    always_ff @(posedge clk) begin
        if (wr_fire && !oor_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign l2_mem_rd_data  = rd_data_q;
    assign l2_mem_rd_valid = rd_valid_q;
    assign l2_mem_wr_done  = wr_done_q;
    assign l2_mem_addr_err = addr_err_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed + randomized bench for l2_mem_responder against a word-array reference model.
module tb_l2_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RDL   = 4;
    localparam int unsigned WRL   = 2;
    localparam int unsigned NW    = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_done;
    logic        busy;
    logic        addr_err;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [31:0] model [NW];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    l2_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .RD_LATENCY (RDL),
        .WR_LATENCY (WRL)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .l2_mem_en         (en),
        .l2_mem_wr_en      (wr_en),
        .l2_mem_access_addr(addr),
        .l2_mem_wr_data    (wdata),
        .l2_mem_rd_data    (rd_data),
        .l2_mem_rd_valid   (rd_valid),
        .l2_mem_wr_done    (wr_done),
        .l2_mem_busy       (busy),
        .l2_mem_addr_err   (addr_err)
    );

    function automatic bit is_oor(input logic [31:0] a);
        return (a / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (is_oor(a)) return 32'h0;
        return model[a / 4];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction from acceptance to the first idle cycle, checking every cycle.
    task automatic txn(input string ctx, input bit w, input logic [31:0] a, input logic [31:0] d);
        int unsigned lat    = w ? WRL : RDL;
        bit          bad    = is_oor(a);
        logic [31:0] exp_rd = w ? last_rd : ref_read(a);
        en = 1'b1; wr_en = w; addr = a; wdata = d;
        @(posedge clk);
        for (int c = 0; c <= int'(lat) + 1; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d busy", ctx, c), busy, (c <= int'(lat)));
            chk($sformatf("%s c%0d rd_valid", ctx, c), rd_valid, (c == int'(lat)) && !w);
            chk($sformatf("%s c%0d wr_done", ctx, c), wr_done, (c == int'(lat)) && w);
            chk($sformatf("%s c%0d addr_err", ctx, c), addr_err, (c == int'(lat)) && bad);
            chk($sformatf("%s c%0d rd_data", ctx, c), rd_data, (c >= int'(lat)) ? exp_rd : last_rd);
            if (c == 0) begin
                en    = 1'b0;
                wr_en = 1'($urandom_range(0, 1));
                addr  = $urandom;
                wdata = $urandom;
            end
        end
        if (!w) last_rd = exp_rd;
        if (w && !bad) model[a / 4] = d;
    endtask

    // Two reads with l2_mem_en held high: the second is only taken once the first has responded.
    task automatic b2b(input string ctx, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_a = ref_read(a);
        logic [31:0] exp_b = ref_read(b);
        logic [31:0] exp_d;
        en = 1'b1; wr_en = 1'b0; addr = a;
        @(posedge clk);
        for (int c = 0; c <= 2 * int'(RDL) + 2; c++) begin
            @(negedge clk);
            if (c < int'(RDL)) exp_d = last_rd;
            else if (c < 2 * int'(RDL) + 1) exp_d = exp_a;
            else exp_d = exp_b;
            chk($sformatf("%s c%0d busy", ctx, c), busy, (c <= 2 * int'(RDL) + 1));
            chk($sformatf("%s c%0d rd_valid", ctx, c), rd_valid,
                (c == int'(RDL)) || (c == 2 * int'(RDL) + 1));
            chk($sformatf("%s c%0d wr_done", ctx, c), wr_done, 1'b0);
            chk($sformatf("%s c%0d addr_err", ctx, c), addr_err, 1'b0);
            chk($sformatf("%s c%0d rd_data", ctx, c), rd_data, exp_d);
            if (c == 0) addr = b;
            if (c == int'(RDL) + 1) en = 1'b0;
        end
        last_rd = exp_b;
    endtask

    // Reset lands mid-transaction, before the commit/response edge.
    task automatic reset_mid(input string ctx, input bit w, input logic [31:0] a, input logic [31:0] d);
        int unsigned lat = w ? WRL : RDL;
        en = 1'b1; wr_en = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        chk({ctx, " busy before reset"}, busy, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({ctx, " rst busy"}, busy, 1'b0);
        chk({ctx, " rst rd_valid"}, rd_valid, 1'b0);
        chk({ctx, " rst wr_done"}, wr_done, 1'b0);
        chk({ctx, " rst addr_err"}, addr_err, 1'b0);
        chk({ctx, " rst rd_data"}, rd_data, 32'h0);
        for (int c = 0; c <= int'(lat) + 1; c++) begin
            @(negedge clk);
            chk($sformatf("%s hold c%0d rd_valid", ctx, c), rd_valid, 1'b0);
            chk($sformatf("%s hold c%0d wr_done", ctx, c), wr_done, 1'b0);
        end
        rst_n   = 1'b1;
        last_rd = 32'h0;
    endtask

    initial begin
        logic [31:0] a;
        bit          w;

        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset rd_valid", rd_valid, 1'b0);
        chk("reset wr_done", wr_done, 1'b0);
        chk("reset addr_err", addr_err, 1'b0);
        chk("reset rd_data", rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        txn("wr 0x10", 1'b1, 32'h10, 32'hA5A5_0001);
        txn("rd 0x10", 1'b0, 32'h10, 32'h0);

        for (int i = 0; i < int'(NW); i++) begin
            if (i != 4) txn("prefill", 1'b1, 32'(i * 4), $urandom);
        end

        b2b("held en 0x20", 32'h20, 32'h24);
        b2b("b2b 0x4/0x8", 32'h4, 32'h8);

        txn("rd oor", 1'b0, 32'h0000_1000, 32'h0);
        txn("wr oor", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        txn("rd 0x0 after oor wr", 1'b0, 32'h0, 32'h0);

        txn("wr 0x40", 1'b1, 32'h40, 32'h1234_5678);
        txn("rd 0x40", 1'b0, 32'h40, 32'h0);
        txn("rd 0x44", 1'b0, 32'h44, 32'h0);

        reset_mid("rst in wr 0x30", 1'b1, 32'h30, ~model[12]);
        txn("rd 0x30 after abort", 1'b0, 32'h30, 32'h0);
        reset_mid("rst in rd 0x20", 1'b0, 32'h20, 32'h0);
        txn("rd 0x20 after reset", 1'b0, 32'h20, 32'h0);

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(1, 32'h000F_FFFF) << 12) | $urandom_range(0, 4095);
            else
                a = ($urandom_range(0, NW - 1) << 2) | $urandom_range(0, 3);
            txn($sformatf("rand%0d", i), w, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
